// File: rtl/rob_sn_allocator_pkg.sv
// Shared defaults and count-update encoding for the ROB sequence-number allocator.
// The depth/bitwidth defaults stand in for ROB_DEPTH / ROB_BITWIDTH of the wider codebase.
package rob_sn_allocator_pkg;

    localparam int ROB_DEPTH    = 16;
    localparam int ROB_BITWIDTH = 32;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // A simultaneous allocate and retire leaves the occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic alloc_fire, input logic retire_fire);
        case ({alloc_fire, retire_fire})
            2'b10:   return CNT_INC;
            2'b01:   return CNT_DEC;
            default: return CNT_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/rob_SnPtr.sv
// Wrapping sequence-number pointer; wraps naturally at 2**p_ptrwidth (== ROB depth).
// clr (flush) and rst both return the pointer to SN 0.
module rob_SnPtr #(
    parameter int p_ptrwidth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  incr,
    output logic [p_ptrwidth-1:0] ptr
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (incr) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rob_sn_allocator.sv
// Hands out in-order SNs to dispatch, frees them from the ROB dequeue stream and
// republishes each retirement as a registered SN-tagged event one cycle later.
module rob_sn_allocator
    import rob_sn_allocator_pkg::*;
#(
    parameter int p_depth    = ROB_DEPTH,
    parameter int p_ptrwidth = $clog2(p_depth),
    parameter int p_bitwidth = ROB_BITWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_en,
    output logic                  alloc_rdy,
    output logic [p_ptrwidth-1:0] alloc_sn,
    input  logic                  flush,
    input  logic                  deq_front_cpl,
    input  logic [p_bitwidth-1:0] deq_front_data,
    output logic                  retire_val,
    output logic [p_ptrwidth-1:0] retire_sn,
    output logic [p_bitwidth-1:0] retire_data,
    output logic [p_ptrwidth:0]   count,
    output logic                  empty,
    output logic                  err
);

    localparam logic [p_ptrwidth:0] DepthC = p_depth[p_ptrwidth:0];

    logic [p_ptrwidth-1:0] head_ptr;
    logic [p_ptrwidth-1:0] tail_ptr;
    logic                  alloc_fire;
    logic                  retire_fire;
    logic                  deq_while_empty;
    logic [p_ptrwidth:0]   count_nxt;

    // Readiness comes only from registered count, so a same-cycle retire cannot unblock a full queue.
    assign alloc_rdy       = (count < DepthC);
    assign empty           = (count == '0);
    assign alloc_sn        = tail_ptr;
    assign alloc_fire      = alloc_en && alloc_rdy && !flush;
    assign retire_fire     = deq_front_cpl && !empty && !flush;
    assign deq_while_empty = deq_front_cpl && empty;

    rob_SnPtr #(.p_ptrwidth(p_ptrwidth)) u_head_ptr (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .incr (retire_fire),
        .ptr  (head_ptr)
    );

    rob_SnPtr #(.p_ptrwidth(p_ptrwidth)) u_tail_ptr (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .incr (alloc_fire),
        .ptr  (tail_ptr)
    );

    // NOTE: assign a default first in always_comb so no path leaves count_nxt unassigned (no latch).
    always_comb begin
        count_nxt = count;
        unique case (cnt_op(alloc_fire, retire_fire))
            CNT_INC: count_nxt = count + 1'b1;
            CNT_DEC: count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // Sticky error: a dequeue with nothing outstanding; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (deq_while_empty) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_val  <= 1'b0;
            retire_sn   <= '0;
            retire_data <= '0;
        end else begin
            retire_val <= retire_fire;
            if (retire_fire) begin
                retire_sn   <= head_ptr;
                retire_data <= deq_front_data;
            end
        end
    end

endmodule

// File: tb/tb_rob_sn_allocator.sv
// Self-checking bench: a behavioural occupancy model plus a retire scoreboard queue.
module tb_rob_sn_allocator;

    localparam int Depth = 4;
    localparam int PW    = 2;
    localparam int BW    = 8;

    typedef struct packed {
        logic [PW-1:0] sn;
        logic [BW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_en;
    logic          alloc_rdy;
    logic [PW-1:0] alloc_sn;
    logic          flush;
    logic          deq_front_cpl;
    logic [BW-1:0] deq_front_data;
    logic          retire_val;
    logic [PW-1:0] retire_sn;
    logic [BW-1:0] retire_data;
    logic [PW:0]   count;
    logic          empty;
    logic          err;

    rob_sn_allocator #(
        .p_depth    (Depth),
        .p_ptrwidth (PW),
        .p_bitwidth (BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_en       (alloc_en),
        .alloc_rdy      (alloc_rdy),
        .alloc_sn       (alloc_sn),
        .flush          (flush),
        .deq_front_cpl  (deq_front_cpl),
        .deq_front_data (deq_front_data),
        .retire_val     (retire_val),
        .retire_sn      (retire_sn),
        .retire_data    (retire_data),
        .count          (count),
        .empty          (empty),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t          sb[$];
    int            m_count;
    logic [PW-1:0] m_head;
    logic [PW-1:0] m_tail;
    logic          m_err;
    logic          m_rval;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        exp_t e;
        check("count", 32'(count), 32'(m_count));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("err", 32'(err), 32'(m_err));
        check("retire_val", 32'(retire_val), 32'(m_rval));
        if (retire_val === 1'b1) begin
            if (sb.size() == 0) begin
                check("retire_unexpected", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("retire_sn", 32'(retire_sn), 32'(e.sn));
                check("retire_data", 32'(retire_data), 32'(e.data));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_en = 1'b0;
        flush = 1'b0;
        deq_front_cpl = 1'b0;
        deq_front_data = '0;
        @(posedge clk);
        #1;
        m_count = 0;
        m_head = '0;
        m_tail = '0;
        m_err = 1'b0;
        m_rval = 1'b0;
        sb.delete();
        check("rst_count", 32'(count), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_alloc_rdy", 32'(alloc_rdy), 32'(1));
        check("rst_alloc_sn", 32'(alloc_sn), 32'(0));
        check("rst_retire_val", 32'(retire_val), 32'(0));
        check("rst_retire_sn", 32'(retire_sn), 32'(0));
        check("rst_retire_data", 32'(retire_data), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        rst = 1'b0;
    endtask

    // One cycle: drive, check combinational grant, advance model, check registered outputs.
    task automatic step(input logic a, input logic d, input logic f, input logic [BW-1:0] data);
        logic a_fire;
        logic r_fire;
        alloc_en = a;
        deq_front_cpl = d;
        flush = f;
        deq_front_data = data;
        #1;
        check("alloc_rdy", 32'(alloc_rdy), 32'(m_count < Depth));
        if (a && m_count < Depth) check("alloc_sn", 32'(alloc_sn), 32'(m_tail));
        a_fire = a && (m_count < Depth) && !f;
        r_fire = d && (m_count != 0) && !f;
        if (d && m_count == 0) m_err = 1'b1;
        if (r_fire) sb.push_back('{sn: m_head, data: data});
        @(posedge clk);
        #1;
        if (f) begin
            m_count = 0;
            m_head = '0;
            m_tail = '0;
        end else begin
            if (a_fire) begin
                m_tail = m_tail + 1'b1;
                m_count++;
            end
            if (r_fire) begin
                m_head = m_head + 1'b1;
                m_count--;
            end
        end
        m_rval = r_fire;
        check_regs();
        alloc_en = 1'b0;
        deq_front_cpl = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        do_reset();

        // Fill to full, then a blocked 5th request.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("full_rdy", 32'(alloc_rdy), 32'(0));
        check("full_count", 32'(count), 32'(4));
        step(1'b1, 1'b0, 1'b0, '0);

        // Retire 0xA5 from full.
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        check("a5_sn", 32'(retire_sn), 32'(0));
        check("a5_data", 32'(retire_data), 32'(8'hA5));
        check("a5_rdy", 32'(alloc_rdy), 32'(1));

        // Refill to full; alloc blocked even with a concurrent retire.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        check("full_retire_count", 32'(count), 32'(3));

        // Down to 2, then 10 concurrent alloc+retire cycles across the SN wrap.
        step(1'b0, 1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, BW'(8'h40 + i));
        check("steady_count", 32'(count), 32'(2));

        // Drain, then dequeue while empty.
        step(1'b0, 1'b1, 1'b0, 8'h21);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 8'h23);
        check("empty_err", 32'(err), 32'(1));
        check("empty_rval", 32'(retire_val), 32'(0));

        // Flush at count 3 with concurrent alloc and dequeue.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 8'h77);
        check("flush_count", 32'(count), 32'(0));
        check("flush_sn", 32'(alloc_sn), 32'(0));
        check("flush_err_kept", 32'(err), 32'(1));

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0), BW'($urandom));
        end

        // Mid-stream reset with count 2.
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 8'h99);
        step(1'b1, 1'b0, 1'b0, '0);
        check("pre_rst_count", 32'(count), 32'(2));
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_sn_allocator.md
# rob_sn_allocator

Dispatch-side companion to the reorder buffer (ROB) op-centric queue. It hands out in-order sequence numbers (SNs) to dispatching operations, which later insert into the ROB by SN. It consumes the ROB's in-order dequeue stream (`deq_front_cpl`/`deq_front_data`) to free SNs, and republishes each retirement as a registered, SN-tagged retire event. It sits between dispatch and the ROB and is the sole source of occupancy and backpressure for the ROB.

## Interface
- `p_depth`, default `` `ROB_DEPTH ``: number of ROB entries / SNs; power of two, ≥2.
- `p_ptrwidth`, default `$clog2(p_depth)`: SN width.
- `p_bitwidth`, default `` `ROB_BITWIDTH ``: retire payload width.
- `clk` in, 1: the single clock.
- `rst` in, 1: synchronous reset, active-high.
- `alloc_en` in, 1: dispatch requests an SN this cycle.
- `alloc_rdy` out, 1: an SN is available, i.e. `count < p_depth`.
- `alloc_sn` out, `p_ptrwidth`: SN granted when `alloc_en && alloc_rdy`; equals the tail pointer.
- `flush` in, 1: discard all outstanding SNs.
- `deq_front_cpl` in, 1: ROB dequeued its head entry this cycle.
- `deq_front_data` in, `p_bitwidth`: payload of the dequeued head.
- `retire_val` out, 1: registered retire event.
- `retire_sn` out, `p_ptrwidth`: SN of the retired entry.
- `retire_data` out, `p_bitwidth`: payload of the retired entry.
- `count` out, `p_ptrwidth+1`: outstanding SNs (allocated, not retired).
- `empty` out, 1: `count == 0`.
- `err` out, 1: sticky; set by a dequeue while empty.

## Operation
- State: `head_ptr` and `tail_ptr`, each `p_ptrwidth` bits; `count`; `err`; retire output registers.
- Allocation fires when `alloc_en && alloc_rdy`:
  - `alloc_sn = tail_ptr`.
  - `tail_ptr` increments modulo `p_depth` (natural wrap, no compare logic).
- `alloc_rdy` depends only on registered `count`. It has no combinational path from `deq_front_cpl` or `alloc_en`. When full, an allocation is blocked even if a retire occurs in the same cycle.
- A retire fires when `deq_front_cpl && !empty`:
  - The retire registers load `retire_sn = head_ptr` and `retire_data = deq_front_data`.
  - `head_ptr` increments with wrap.
- A dequeue while empty (`deq_front_cpl && empty`) is ignored: no pointer or count change, `retire_val` is 0 next cycle, and `err` is set. Only `rst` clears `err`.
- Count update, computed from the fire signals:
  - alloc only: +1.
  - retire only: −1.
  - both: unchanged.
  - `count` never exceeds `p_depth` and never underflows.
- Flush: next cycle `head_ptr = tail_ptr = 0`, `count = 0`, and `retire_val = 0`. Flush has priority over a same-cycle allocation (no SN granted; `alloc_rdy` is still driven from `count`) and over a same-cycle retire (dropped). `err` is unaffected.
- Reset values: `head_ptr = tail_ptr = 0`, `count = 0`, `empty = 1`, `alloc_rdy = 1`, `alloc_sn = 0`, `retire_val = 0`, `retire_sn = 0`, `retire_data = 0`, `err = 0`. Reset asserted mid-operation discards all state at the next edge.

## Timing
- `alloc_sn`/`alloc_rdy`: combinational from registers. The grant is valid in the same cycle as `alloc_en`, and the pointer updates at the next edge.
- Retire latency: exactly 1 cycle. `retire_val` is high the cycle after `deq_front_cpl`, for one cycle per dequeue. Back-to-back dequeues give back-to-back retires.
- `count`/`empty` reflect the fires at the following edge.
- Throughput: one allocation and one retire per cycle, concurrently.

## Structure
- `` `ROB_DEPTH `` and `` `ROB_BITWIDTH `` come from `common_defs.v`. No new package is needed.
- Split into two sub-modules:
  - `rob_SnPtr`: a wrapping pointer register with `incr` and `clr` inputs, instantiated twice for head and tail.
  - A top-level that holds the count, err and retire-register logic.

## Test plan
- Reset, then 4 allocs with `p_depth=4` → `alloc_sn` = 0,1,2,3; then `alloc_rdy=0`, `count=4`; a 5th `alloc_en` is not granted.
- Full, then `deq_front_cpl` with data `0xA5` → next cycle `retire_val=1`, `retire_sn=0`, `retire_data=0xA5`, `count=3`, `alloc_rdy=1`.
- Alloc and retire in the same cycle at `count=2` → `count` stays 2, `tail_ptr` and `head_ptr` both advance. Repeat 10 times to cover SN wrap 3→0 → `retire_sn` sequence wraps identically.
- `deq_front_cpl` while empty → `retire_val=0`, `count=0`, `err=1`, and `err` stays high until `rst`.
- `flush` with `count=3` plus a concurrent `alloc_en` and `deq_front_cpl` → next cycle `count=0`, `retire_val=0`, next `alloc_sn=0`.
- Assert `rst` mid-stream with `count=2` → all outputs return to their reset values on the next cycle.
